// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: datapath width, multiply/divide
// operation encodings and the multiply/divide sequencer states.
package mips_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    MD_NONE  = 3'b000,
    MD_MULT  = 3'b001,
    MD_MULTU = 3'b010,
    MD_DIV   = 3'b011,
    MD_DIVU  = 3'b100,
    MD_MTHI  = 3'b101,
    MD_MTLO  = 3'b110,
    MD_NOP7  = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIN  = 2'd3
  } md_state_e;

endpackage

// File: rtl/md_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep or restore.
module md_div_step #(
  parameter int XLEN = mips_pkg::XLEN
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // rem_i < dvs_i always holds, so the top bit of diff is a clean borrow flag
  always_comb begin
    shifted = {rem_i, quo_i[XLEN-1]};
    diff    = shifted - {1'b0, dvs_i};
    if (diff[XLEN]) begin
      rem_o = shifted[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b0};
    end else begin
      rem_o = diff[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: one shift-add or restoring-divide
// step per clock on operand magnitudes, signs applied when results retire.
module mult_div_unit #(
  parameter int XLEN = mips_pkg::XLEN,
  parameter int ITER = mips_pkg::XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  input  logic [2:0]      mdcontrol,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);
  import mips_pkg::*;

  localparam int CW = $clog2(ITER);

  md_state_e         state_q;
  logic [CW-1:0]     cnt_q;
  logic              busy_q, done_q;
  logic [XLEN-1:0]   hi_q, lo_q;

  logic              is_mul_q, a_neg_q, b_neg_q;
  logic [XLEN-1:0]   a_q, mag_a_q, mag_b_q;
  logic [2*XLEN-1:0] p_q;

  md_op_e            op_in;
  logic              free, sgn_in, is_mul_in, acc_mul, acc_div, wr_hi, wr_lo;
  logic [XLEN-1:0]   mag_a_d, mag_b_d, rem_nxt, quo_nxt, res_hi, res_lo;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] prod;

  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? -v : v;
  endfunction

  function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] apply_sign2(input logic [2*XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign op_in     = md_op_e'(mdcontrol);
  assign free      = (state_q == S_IDLE) && !busy_q;
  assign sgn_in    = (op_in == MD_MULT) || (op_in == MD_DIV);
  assign is_mul_in = (op_in == MD_MULT) || (op_in == MD_MULTU);
  assign acc_mul   = start && free && is_mul_in;
  assign acc_div   = start && free && ((op_in == MD_DIV) || (op_in == MD_DIVU));
  assign wr_hi     = start && free && (op_in == MD_MTHI);
  assign wr_lo     = start && free && (op_in == MD_MTLO);
  assign mag_a_d   = magnitude(srca, sgn_in);
  assign mag_b_d   = magnitude(srcb, sgn_in);

  // Shift-add step: upper half accumulates, lower half shifts out the multiplier
  assign mul_sum = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, mag_a_q} : '0);

  md_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_i (p_q[2*XLEN-1:XLEN]),
    .quo_i (p_q[XLEN-1:0]),
    .dvs_i (mag_b_q),
    .rem_o (rem_nxt),
    .quo_o (quo_nxt)
  );

  always_comb begin
    prod   = apply_sign2(p_q, a_neg_q ^ b_neg_q);
    res_hi = apply_sign(p_q[2*XLEN-1:XLEN], a_neg_q);
    res_lo = apply_sign(p_q[XLEN-1:0], a_neg_q ^ b_neg_q);
    if (is_mul_q) begin
      res_hi = prod[2*XLEN-1:XLEN];
      res_lo = prod[XLEN-1:0];
    end else if (mag_b_q == '0) begin
      res_hi = a_q;
      res_lo = '1;
    end
  end

  // Operand/working registers carry no reset; they are always reloaded on accept
  always_ff @(posedge clk) begin
    if (acc_mul || acc_div) begin
      is_mul_q <= is_mul_in;
      a_neg_q  <= sgn_in && srca[XLEN-1];
      b_neg_q  <= sgn_in && srcb[XLEN-1];
      a_q      <= srca;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      p_q      <= {{XLEN{1'b0}}, (is_mul_in ? mag_b_d : mag_a_d)};
    end else if (state_q == S_MUL) begin
      p_q <= {mul_sum, p_q[XLEN-1:1]};
    end else if (state_q == S_DIV) begin
      p_q <= {rem_nxt, quo_nxt};
    end
  end

  // busy/done/hi/lo are registered FSM outputs; busy drops one edge after done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (done_q) busy_q <= 1'b0;
          if (acc_mul) begin
            state_q <= S_MUL;
            cnt_q   <= CW'(ITER - 1);
            busy_q  <= 1'b1;
          end else if (acc_div) begin
            state_q <= (srcb == '0) ? S_FIN : S_DIV;
            cnt_q   <= CW'(ITER - 1);
            busy_q  <= 1'b1;
          end else if (wr_hi) begin
            hi_q <= srca;
          end else if (wr_lo) begin
            lo_q <= srca;
          end
        end
        S_MUL, S_DIV: begin
          if (cnt_q == '0) state_q <= S_FIN;
          else             cnt_q   <= cnt_q - CW'(1);
        end
        S_FIN: begin
          hi_q    <= res_hi;
          lo_q    <= res_lo;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed operations push expected
// HI/LO and latency; a negedge monitor pops and compares on every done.
module tb_mult_div_unit;

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;
  localparam logic [2:0] OP_NOP7  = 3'b111;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] srca, srcb;
  logic [2:0]  mdcontrol;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  mult_div_unit #(.XLEN(32), .ITER(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .srca      (srca),
    .srcb      (srcb),
    .mdcontrol (mdcontrol),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && done) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk({mon_e.name, "_hi"}, hi, mon_e.hi);
        chk({mon_e.name, "_lo"}, lo, mon_e.lo);
        chk({mon_e.name, "_latency"}, cyc - mon_e.acc, mon_e.lat);
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input string nm, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                       input int lat);
    exp_t e;
    srca = a; srcb = b; mdcontrol = op; start = 1'b1;
    @(posedge clk); #1;
    e.name = nm; e.hi = eh; e.lo = el; e.acc = cyc; e.lat = lat;
    sbq.push_back(e);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk({nm, "_timeout"}, 64'd1, 64'd0);
  endtask

  task automatic run(input string nm, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                     input int lat);
    issue(nm, op, a, b, eh, el, lat);
    wait_idle(nm);
  endtask

  initial begin
    int          n;
    logic [31:0] prev_hi, prev_lo;

    reset = 1'b1; start = 1'b0; srca = '0; srcb = '0; mdcontrol = OP_NONE;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    issue("mult_neg1x2", OP_MULT, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
    chk("mult_busy_cycles", n, 34);
    @(posedge clk); #1;

    run("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33);
    run("mult_minsq", OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33);
    run("mult_m3x5", OP_MULT, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 33);
    run("div_m7d2", OP_DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
    run("div_7dm2", OP_DIV, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33);
    run("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33);
    run("divu_100d7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33);
    run("divu_by0", OP_DIVU, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF, 1);
    run("div_by0", OP_DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1);

    // Second start mid-operation must be ignored; operand changes must not leak in
    prev_hi = hi; prev_lo = lo;
    issue("mult_busy_ign", OP_MULT, 32'd6, 32'd7, 32'd0, 32'd42, 33);
    srca = 32'h0BADF00D;
    repeat (4) begin @(posedge clk); #1; end
    chk("hold_hi_busy", hi, prev_hi);
    chk("hold_lo_busy", lo, prev_lo);
    srca = 32'h00000999; srcb = 32'd3; mdcontrol = OP_DIVU; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; srca = 32'hDEADBEEF;
    wait_idle("mult_busy_ign");
    repeat (40) @(posedge clk);
    #1;
    chk("ignored_start_empty", sbq.size(), 0);

    srca = 32'hAAAA5555; mdcontrol = OP_MTHI; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("mthi_hi", hi, 32'hAAAA5555);
    chk("mthi_lo_kept", lo, 32'd42);
    chk("mthi_busy", busy, 0);
    chk("mthi_done", done, 0);

    srca = 32'h12345678; mdcontrol = OP_NONE; start = 1'b1;
    @(posedge clk); #1;
    mdcontrol = OP_NOP7;
    @(posedge clk); #1;
    start = 1'b0;
    chk("nop_busy", busy, 0);
    chk("nop_hi", hi, 32'hAAAA5555);
    chk("nop_lo", lo, 32'd42);

    // Asynchronous reset in the middle of a multiply
    srca = 32'd3; srcb = 32'd4; mdcontrol = OP_MULT; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    srca = 32'h00001234; mdcontrol = OP_MTLO; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("mtlo_lo", lo, 32'h00001234);
    chk("mtlo_done", done, 0);
    chk("mtlo_busy", busy, 0);
    run("mult_after_rst", OP_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 33);

    repeat (5) @(posedge clk);
    #1;
    chk("sb_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand and HI/LO width.
REQ-002 SHALL have parameter ITER, default 32, meaning iterations per multiply/divide (equals XLEN).
REQ-003 SHALL have port clk  input  1  single system clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port srca  input  32  first operand (multiplicand / dividend / mthi-mtlo source).
REQ-006 SHALL have port srcb  input  32  second operand (multiplier / divisor).
REQ-007 SHALL have port mdcontrol  input  3  operation: 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 none.
REQ-008 SHALL have port start  input  1  request, sampled on a rising clk edge.
REQ-009 SHALL have port busy  output  1  operation in progress, new start ignored.
REQ-010 SHALL have port done  output  1  one-cycle pulse, HI/LO just updated by mult/div.
REQ-011 SHALL have ports hi and lo  output  32 each  architectural HI/LO registers.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DIV, FIN.
REQ-013 SHALL accept start only in IDLE; start while busy=1 SHALL be ignored with no side effects.
REQ-014 SHALL latch srca, srcb and mdcontrol on the accepting edge; later operand changes SHALL NOT affect the result.
REQ-015 IDLE + start + mult/multu SHALL go to MUL; div/divu with srcb!=0 SHALL go to DIV; div/divu with srcb==0 SHALL go to FIN.
REQ-016 MUL/DIV SHALL run exactly ITER iterations (one per clk, 5-bit down-counter), then go to FIN.
REQ-017 FIN SHALL write hi/lo, assert done for exactly that cycle, return to IDLE on next edge.
REQ-018 Latency: for mult/div, done SHALL be high in the cycle following the 33rd edge after the accepting edge; for divide-by-zero, in the cycle following the 1st edge.
REQ-019 busy SHALL be 1 from the accepting edge until the edge leaving FIN, including the done cycle.
REQ-020 hi/lo SHALL hold previous values while busy; only FIN, mthi, mtlo update them.
REQ-021 mult/multu SHALL produce the full 64-bit product, hi=[63:32], lo=[31:0]; multu unsigned, mult two's-complement.
REQ-022 Signed ops SHALL compute on magnitudes (32-bit unsigned, so |0x80000000| is exact) and apply signs in FIN.
REQ-023 div/divu SHALL use restoring division; lo=quotient, hi=remainder.
REQ-024 Signed quotient sign = sign(srca) XOR sign(srcb); remainder sign = sign(srca).
REQ-025 Divide by zero SHALL give hi=srca, lo=32'hFFFFFFFF (both signed and unsigned).
REQ-026 div 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000, no other indication.
REQ-027 mthi/mtlo with start in IDLE SHALL write srca to hi/lo on that edge, never assert busy or done.
REQ-028 mdcontrol 000 or 111 with start SHALL be a no-op.

Reset
REQ-029 reset SHALL immediately force state IDLE, busy=0, done=0, hi=0, lo=0, counter=0.
REQ-030 reset mid-operation SHALL discard partial results; first start after release SHALL run normally.

Structure
REQ-031 XLEN, mdcontrol encodings and the FSM state enum SHALL live in shared package mips_pkg.
REQ-032 Restoring-division iteration datapath SHALL be sub-module md_div_step (combinational, one iteration); multiply stays inline.
REQ-033 The block SHALL sit beside alu on the same srca/srcb buses and SHALL NOT modify ALU encodings.

Verification
REQ-034 mult srca=0xFFFFFFFF, srcb=0x00000002 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE, done 33 edges after accept, busy high 34 cycles.
REQ-035 multu 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-036 div srca=0xFFFFFFF9 (-7), srcb=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-037 divu srca=100, srcb=0 -> hi=0x00000064, lo=0xFFFFFFFF, done one edge after accept.
REQ-038 start mult, second start divu at cycle 5 with srca changed -> second ignored, result from first operands.
REQ-039 reset at cycle 10 of a mult -> busy=0, done=0, hi=lo=0; mtlo srca=0x1234 next -> lo=0x00001234 after one edge, no done.
